alu_sequencer: RTL and testbench

- Shares one sign-magnitude ALU (24-bit R/S, ctl_f/ctl_e select, registered result/sign/cont) between NUM_REQ requesters.
- Round-robin arbitration, operand latching, ALU sequencing and wait-for-result, single response channel tagged with requester id.
- Sits between the datapath clients and the alu instance; owns all alu input pins.

---
 rtl/alu_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: round-robin front end sharing one registered sign-magnitude ALU.
// Define ALU_SEQ_PRIO_EN to give requester 0 strict priority over the rest.

module alu_sequencer #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int ALU_LAT  = 1,
  parameter int MAX_WAIT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [24*NUM_REQ-1:0]   req_R,
  input  logic [24*NUM_REQ-1:0]   req_S,
  input  logic [NUM_REQ-1:0]      req_f,
  input  logic [NUM_REQ-1:0]      req_e,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [23:0]             rsp_result,
  output logic                    rsp_sign,
  output logic                    rsp_err,
  output logic [23:0]             alu_R,
  output logic [23:0]             alu_S,
  output logic                    alu_ctl_f,
  output logic                    alu_ctl_e,
  input  logic [23:0]             alu_result,
  input  logic                    alu_sign,
  input  logic                    alu_cont,
  output logic                    busy
);

  localparam int LAT_W  = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [ID_W:0] NR = (ID_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [23:0]       op_r_q, op_r_d;
  logic [23:0]       op_s_q, op_s_d;
  logic              op_f_q, op_f_d;
  logic              op_e_q, op_e_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [23:0]       rsp_result_q, rsp_result_d;
  logic              rsp_sign_q, rsp_sign_d;
  logic              rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] cand;
  logic               gnt_any;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W:0]      arb_sum;
  logic               accept;
  logic [23:0]        sel_r, sel_s;
  logic               sel_f, sel_e;
  logic [ID_W:0]      ptr_nxt;

  // Search upward from the pointer with wrap; first candidate wins.
  always_comb begin
    cand    = req_valid;
`ifdef ALU_SEQ_PRIO_EN
    cand[0] = 1'b0;
`endif
    gnt_any = 1'b0;
    gnt_idx = '0;
    arb_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (arb_sum >= NR) arb_sum = arb_sum - NR;
      if (!gnt_any && cand[arb_sum[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = arb_sum[ID_W-1:0];
      end
    end
`ifdef ALU_SEQ_PRIO_EN
    if (req_valid[0]) begin
      gnt_any = 1'b1;
      gnt_idx = '0;
    end
`endif
  end

  assign accept = (state_q == S_IDLE) && gnt_any && rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_r = '0;
    sel_s = '0;
    sel_f = 1'b0;
    sel_e = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == ID_W'(k)) begin
        sel_r = req_R[24*k +: 24];
        sel_s = req_S[24*k +: 24];
        sel_f = req_f[k];
        sel_e = req_e[k];
      end
    end
  end

  always_comb begin
    ptr_nxt = {1'b0, id_q} + (ID_W+1)'(1);
    if (ptr_nxt >= NR) ptr_nxt = '0;
`ifdef ALU_SEQ_PRIO_EN
    if (ptr_nxt == '0) ptr_nxt = (ID_W+1)'(1);
`endif
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    op_r_d       = op_r_q;
    op_s_d       = op_s_q;
    op_f_d       = op_f_q;
    op_e_d       = op_e_q;
    lat_d        = lat_q;
    wait_d       = wait_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_sign_d   = rsp_sign_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          id_d    = gnt_idx;
          op_r_d  = sel_r;
          op_s_d  = sel_s;
          op_f_d  = sel_f;
          op_e_d  = sel_e;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        lat_d   = LAT_W'(ALU_LAT);
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q > LAT_W'(1)) begin
          lat_d = lat_q - LAT_W'(1);
        end else begin
          lat_d = '0;
          if (!alu_cont || wait_q == WAIT_W'(MAX_WAIT - 1)) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_cont ? 24'd0 : alu_result;
            rsp_sign_d   = alu_cont ? 1'b0 : alu_sign;
            rsp_err_d    = alu_cont;
            op_r_d       = '0;
            op_s_d       = '0;
            op_f_d       = 1'b0;
            op_e_d       = 1'b0;
            state_d      = S_RESP;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          rsp_result_d = '0;
          rsp_sign_d   = 1'b0;
          rsp_err_d    = 1'b0;
          ptr_d        = ptr_nxt[ID_W-1:0];
          state_d      = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      op_r_q       <= '0;
      op_s_q       <= '0;
      op_f_q       <= 1'b0;
      op_e_q       <= 1'b0;
      lat_q        <= '0;
      wait_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_sign_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      op_r_q       <= op_r_d;
      op_s_q       <= op_s_d;
      op_f_q       <= op_f_d;
      op_e_q       <= op_e_d;
      lat_q        <= lat_d;
      wait_q       <= wait_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_sign_q   <= rsp_sign_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_sign   = rsp_sign_q;
  assign rsp_err    = rsp_err_q;
  assign alu_R      = op_r_q;
  assign alu_S      = op_s_q;
  assign alu_ctl_f  = op_f_q;
  assign alu_ctl_e  = op_e_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of arbitration, latency, backpressure,
// timeout and async reset, with a small registered sign-magnitude ALU model.

module tb_alu_sequencer;

  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [24*NR-1:0] req_R, req_S;
  logic [NR-1:0]   req_f, req_e;
  logic            rsp_valid, rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [23:0]     rsp_result;
  logic            rsp_sign, rsp_err;
  logic [23:0]     alu_R, alu_S;
  logic            alu_ctl_f, alu_ctl_e;
  logic [23:0]     alu_result = '0;
  logic            alu_sign = 1'b0;
  logic            cont_force;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  alu_sequencer #(
    .NUM_REQ(NR), .ID_W(IW), .ALU_LAT(1), .MAX_WAIT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_R(req_R), .req_S(req_S), .req_f(req_f), .req_e(req_e),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_sign(rsp_sign), .rsp_err(rsp_err),
    .alu_R(alu_R), .alu_S(alu_S),
    .alu_ctl_f(alu_ctl_f), .alu_ctl_e(alu_ctl_e),
    .alu_result(alu_result), .alu_sign(alu_sign), .alu_cont(cont_force),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered ALU: 1 sign + 9 integer + 14 fraction bits.
  always @(posedge clk) begin
    logic [45:0] prod;
    prod = 46'(alu_R[22:0]) * 46'(alu_S[22:0]);
    if (alu_ctl_f) begin
      if (alu_ctl_e) alu_result <= {alu_R[23], alu_R[22:0] - alu_S[22:0]};
      else           alu_result <= {alu_R[23], alu_R[22:0] + alu_S[22:0]};
      alu_sign <= alu_R[23];
    end else begin
      alu_result <= {alu_R[23] ^ alu_S[23], prod[36:14]};
      alu_sign   <= alu_R[23] ^ alu_S[23];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int k, input logic [23:0] r,
                       input logic [23:0] s, input logic f,
                       input logic [NR-1:0] exp_rdy, input string tag);
    req_valid           = '0;
    req_valid[k]        = 1'b1;
    req_R[24*k +: 24]   = r;
    req_S[24*k +: 24]   = s;
    req_f[k]            = f;
    req_e[k]            = 1'b0;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [NR-1:0] fair_exp [5];
  int n;
  int last;
  logic bad;

  initial begin
`ifdef ALU_SEQ_PRIO_EN
    fair_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    rst        = 1'b0;
    req_valid  = '1;
    req_R      = '0;
    req_S      = '0;
    req_f      = '0;
    req_e      = '0;
    rsp_ready  = 1'b1;
    cont_force = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_alu_R", 32'(alu_R), 0);
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);

    // single add on requester 2
    issue(2, 24'h00C000, 24'h014000, 1'b1, 4'b0100, "add");
    chk("add_exec_ready", 32'(req_ready), 0);
    chk("add_alu_R", 32'(alu_R), 32'h00C000);
    chk("add_ctl_f", 32'(alu_ctl_f), 1);
    wait_rsp(n);
    chk("add_latency", 32'(n), 3);
    chk("add_id", 32'(rsp_id), 2);
    chk("add_result", 32'(rsp_result), 32'h020000);
    chk("add_err", 32'(rsp_err), 0);
    @(negedge clk);
    chk("add_idle", 32'({busy, rsp_valid, alu_R}), 0);

    // multiply on requester 1
    issue(1, 24'h00C000, 24'h010000, 1'b0, 4'b0010, "mul");
    wait_rsp(n);
    chk("mul_id", 32'(rsp_id), 1);
    chk("mul_result", 32'(rsp_result), 32'h030000);
    @(negedge clk);

    // requester 3 leaves the pointer at 0
    issue(3, 24'h004000, 24'h004000, 1'b1, 4'b1000, "r3");
    wait_rsp(n);
    chk("r3_id", 32'(rsp_id), 3);
    chk("r3_result", 32'(rsp_result), 32'h008000);
    @(negedge clk);

    // fairness with every requester valid
    for (int k = 0; k < NR; k++) begin
      req_R[24*k +: 24] = 24'h004000;
      req_S[24*k +: 24] = 24'h004000;
      req_f[k]          = 1'b1;
    end
    req_valid = '1;
    #1;
    last = cyc;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (req_ready == '0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("fair_gnt%0d", g), 32'(req_ready), 32'(fair_exp[g]));
      if (g > 0) chk($sformatf("fair_gap%0d", g), 32'(cyc - last), 4);
      last = cyc;
      @(negedge clk);
    end
    req_valid = '0;
    wait_rsp(n);
    chk("fair_last_id", 32'(rsp_id), 0);
    @(negedge clk);

    // backpressure on the response channel
    rsp_ready = 1'b0;
    issue(0, 24'h008000, 24'h008000, 1'b1, 4'b0001, "bp");
    wait_rsp(n);
    chk("bp_valid", 32'(rsp_valid), 1);
    chk("bp_result", 32'(rsp_result), 32'h010000);
    req_valid = 4'b1110;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_id == 0 && rsp_result == 24'h010000 &&
            req_ready == '0 && busy)) bad = 1'b1;
    end
    chk("bp_stable", 32'(bad), 0);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'({busy, rsp_valid}), 0);

    // timeout with the ALU stuck busy
    cont_force = 1'b1;
    issue(3, 24'h004000, 24'h004000, 1'b1, 4'b1000, "to");
    wait_rsp(n);
    chk("to_latency", 32'(n), 66);
    chk("to_err", 32'(rsp_err), 1);
    chk("to_result", 32'(rsp_result), 0);
    chk("to_id", 32'(rsp_id), 3);
    cont_force = 1'b0;
    @(negedge clk);
    issue(2, 24'h004000, 24'h008000, 1'b1, 4'b0100, "post_to");
    wait_rsp(n);
    chk("post_to_result", 32'(rsp_result), 32'h00C000);
    chk("post_to_err", 32'(rsp_err), 0);
    @(negedge clk);

    // async reset in the middle of WAIT
    cont_force = 1'b1;
    issue(1, 24'h004000, 24'h004000, 1'b1, 4'b0010, "ar");
    repeat (5) @(negedge clk);
    chk("ar_busy_before", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_alu", 32'({alu_R, alu_S, alu_ctl_f}), 0);
    chk("ar_rsp", 32'({rsp_valid, rsp_err, rsp_result}), 0);
    @(negedge clk);
    cont_force = 1'b0;
    req_R[24*3 +: 24] = 24'h004000;
    req_S[24*3 +: 24] = 24'h004000;
    req_valid = 4'b1010;
    rst       = 1'b1;
    #1;
    chk("ar_first_gnt", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    req_valid = '0;
    wait_rsp(n);
    chk("ar_id", 32'(rsp_id), 1);
    chk("ar_result", 32'(rsp_result), 32'h008000);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
